solver_dispatch_arbiter: RTL and testbench

Parametrised successor to the 4-bit MSB one-hot encoder. It dispatches Mandelbrot pixel jobs from the job generator to N_UNITS iteration solvers. Each cycle it picks one idle solver, either by fixed MSB priority or by round-robin, and issues a registered one-hot grant pulse. It sits between the pixel-coordinate generator and the solver array, forming the load balancer.

---
 rtl/fract_dispatch_pkg.sv | 30 +++
 rtl/msb_onehot_n.sv | 31 +++
 rtl/solver_dispatch_arbiter.sv | 114 +++++++++++
 tb/tb_solver_dispatch_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fract_dispatch_pkg.sv
// Shared constants and helpers for the Mandelbrot job dispatch logic.
package fract_dispatch_pkg;

    localparam int MAX_UNITS = 32;

    // Ceiling log2, never less than 1 so index ports always have a bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic logic [MAX_UNITS-1:0] msb_onehot(input logic [MAX_UNITS-1:0] vec);
        logic [MAX_UNITS-1:0] result;
        result = '0;
        for (int i = 0; i < MAX_UNITS; i++) begin
            if (vec[i]) begin
                result    = '0;
                result[i] = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/msb_onehot_n.sv
// Combinational MSB-first one-hot encoder of configurable width.
module msb_onehot_n
    import fract_dispatch_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int IDX_W = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [MAX_UNITS-1:0] padded;
    logic [MAX_UNITS-1:0] full;

    always_comb begin
        padded             = '0;
        padded[WIDTH-1:0]  = in;
        full               = msb_onehot(padded);
        onehot             = full[WIDTH-1:0];
        any                = |full;
        idx                = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/solver_dispatch_arbiter.sv
// Hands pixel jobs to idle solvers with fixed-MSB or round-robin priority.
// Optional stall counter enabled by defining DISPATCH_STATS_EN.
module solver_dispatch_arbiter
    import fract_dispatch_pkg::*;
#(
    parameter int N_UNITS     = 8,
    parameter int ROUND_ROBIN = 0,
    parameter int CNT_W       = 16,
    localparam int IDX_W      = clog2(N_UNITS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_UNITS-1:0] idle,
    input  logic               job_valid,
    output logic               job_ready,
    output logic [N_UNITS-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid,
    output logic [CNT_W-1:0]   jobs_dispatched
`ifdef DISPATCH_STATS_EN
    ,
    output logic [15:0]        stall_cycles
`endif
);

    logic [N_UNITS-1:0] pend;
    logic [IDX_W-1:0]   last_idx;
    logic [IDX_W-1:0]   rot;
    logic [N_UNITS-1:0] eligible;
    logic [N_UNITS-1:0] rotated;
    logic [N_UNITS-1:0] rot_onehot;
    logic [IDX_W-1:0]   rot_idx;
    logic               rot_any;
    logic [N_UNITS-1:0] sel_onehot;
    logic [IDX_W-1:0]   sel_idx;
    logic               transfer;
    int                 src;
    int                 idx_sum;

    assign eligible  = idle & ~pend;
    assign rot       = (ROUND_ROBIN != 0) ? last_idx : '0;
    assign job_ready = rot_any & ~reset;
    assign transfer  = job_valid & job_ready;

    // Rotating by last_idx puts last_idx-1 at the top bit and last_idx at bit 0,
    // so a plain MSB search walks the round-robin order.
    always_comb begin
        rotated = '0;
        src     = 0;
        for (int j = 0; j < N_UNITS; j++) begin
            src = j + int'(rot);
            if (src >= N_UNITS) begin
                src = src - N_UNITS;
            end
            rotated[j] = eligible[IDX_W'(src)];
        end
    end

    msb_onehot_n #(.WIDTH(N_UNITS)) u_pick (
        .in     (rotated),
        .onehot (rot_onehot),
        .idx    (rot_idx),
        .any    (rot_any)
    );

    always_comb begin
        sel_onehot = '0;
        idx_sum    = 0;
        for (int j = 0; j < N_UNITS; j++) begin
            idx_sum = j + int'(rot);
            if (idx_sum >= N_UNITS) begin
                idx_sum = idx_sum - N_UNITS;
            end
            sel_onehot[IDX_W'(idx_sum)] = rot_onehot[j];
        end
        idx_sum = int'(rot_idx) + int'(rot);
        if (idx_sum >= N_UNITS) begin
            idx_sum = idx_sum - N_UNITS;
        end
        sel_idx = IDX_W'(idx_sum);
    end

    // pend blocks a solver from a second grant until it has shown idle low once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant           <= '0;
            grant_idx       <= '0;
            grant_valid     <= 1'b0;
            jobs_dispatched <= '0;
            pend            <= '0;
            last_idx        <= IDX_W'(N_UNITS - 1);
        end else begin
            pend        <= (pend & idle) | (transfer ? sel_onehot : '0);
            grant       <= transfer ? sel_onehot : '0;
            grant_valid <= transfer;
            if (transfer) begin
                grant_idx       <= sel_idx;
                last_idx        <= sel_idx;
                jobs_dispatched <= jobs_dispatched + CNT_W'(1);
            end
        end
    end

`ifdef DISPATCH_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (job_valid && !job_ready && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_solver_dispatch_arbiter.sv
// Directed bench: fixed-priority instance (CNT_W=4) and round-robin instance, N_UNITS=4.
module tb_solver_dispatch_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] idle_f;
    logic       jv_f;
    logic       ready_f;
    logic [3:0] grant_f;
    logic [1:0] idx_f;
    logic       gv_f;
    logic [3:0] jobs_f;
    logic [3:0] idle_r;
    logic       jv_r;
    logic       ready_r;
    logic [3:0] grant_r;
    logic [1:0] idx_r;
    logic       gv_r;
    logic [15:0] jobs_r;
`ifdef DISPATCH_STATS_EN
    logic [15:0] stall_f;
    logic [15:0] stall_r;
`endif

    int errors;
    int checks;
    logic [3:0] rr_exp [8];
    logic [1:0] rr_idx_exp [8];

    solver_dispatch_arbiter #(.N_UNITS(4), .ROUND_ROBIN(0), .CNT_W(4)) dut_fix (
        .clk             (clk),
        .reset           (reset),
        .idle            (idle_f),
        .job_valid       (jv_f),
        .job_ready       (ready_f),
        .grant           (grant_f),
        .grant_idx       (idx_f),
        .grant_valid     (gv_f),
        .jobs_dispatched (jobs_f)
`ifdef DISPATCH_STATS_EN
        ,
        .stall_cycles    (stall_f)
`endif
    );

    solver_dispatch_arbiter #(.N_UNITS(4), .ROUND_ROBIN(1), .CNT_W(16)) dut_rr (
        .clk             (clk),
        .reset           (reset),
        .idle            (idle_r),
        .job_valid       (jv_r),
        .job_ready       (ready_r),
        .grant           (grant_r),
        .grant_idx       (idx_r),
        .grant_valid     (gv_r),
        .jobs_dispatched (jobs_r)
`ifdef DISPATCH_STATS_EN
        ,
        .stall_cycles    (stall_r)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rr_exp     = '{4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
        rr_idx_exp = '{2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3};

        reset  = 1'b1;
        idle_f = 4'b1111;
        jv_f   = 1'b1;
        idle_r = 4'b1111;
        jv_r   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            applyStimulus;
            checkOutput("rst_grant", grant_f, 4'b0000);
            checkOutput("rst_gv", gv_f, 0);
            checkOutput("rst_ready", ready_f, 0);
            checkOutput("rst_jobs", jobs_f, 0);
            checkOutput("rst_rr_ready", ready_r, 0);
            checkOutput("rst_rr_gv", gv_r, 0);
        end
        reset = 1'b0;
        jv_f  = 1'b0;
        jv_r  = 1'b0;
        applyStimulus;
        checkOutput("idle_gv", gv_f, 0);

        // Fixed priority: highest eligible index wins
        idle_f = 4'b0110;
        jv_f   = 1'b1;
        #1;
        checkOutput("fix_ready", ready_f, 1);
        applyStimulus;
        checkOutput("fix_grant1", grant_f, 4'b0100);
        checkOutput("fix_idx1", idx_f, 2);
        checkOutput("fix_gv1", gv_f, 1);
        checkOutput("fix_jobs1", jobs_f, 1);
        idle_f = 4'b0010;
        applyStimulus;
        checkOutput("fix_grant2", grant_f, 4'b0010);
        checkOutput("fix_idx2", idx_f, 1);
        checkOutput("fix_jobs2", jobs_f, 2);
        jv_f = 1'b0;
        applyStimulus;
        checkOutput("fix_nogrant", grant_f, 4'b0000);
        checkOutput("fix_nogv", gv_f, 0);
        checkOutput("fix_idxhold", idx_f, 1);

        // Pend hold-off on unit 0
        idle_f = 4'b0001;
        jv_f   = 1'b1;
        #1;
        checkOutput("pend_ready0", ready_f, 1);
        applyStimulus;
        checkOutput("pend_grant", grant_f, 4'b0001);
        checkOutput("pend_jobs", jobs_f, 3);
        checkOutput("pend_blocked", ready_f, 0);
        applyStimulus;
        checkOutput("pend_nogv1", gv_f, 0);
        applyStimulus;
        checkOutput("pend_nogv2", gv_f, 0);
        checkOutput("pend_jobshold", jobs_f, 3);
        idle_f = 4'b0000;
        applyStimulus;
        checkOutput("pend_nogv3", gv_f, 0);
        idle_f = 4'b0001;
        #1;
        checkOutput("pend_ready1", ready_f, 1);
        applyStimulus;
        checkOutput("pend_regrant", grant_f, 4'b0001);
        checkOutput("pend_jobs4", jobs_f, 4);

        // Counter wrap: 13 more back-to-back transfers, 17 total
        for (int k = 0; k < 13; k++) begin
            idle_f = (k % 2 == 0) ? 4'b0010 : 4'b0001;
            jv_f   = 1'b1;
            applyStimulus;
            checkOutput("wrap_gv", gv_f, 1);
            if (k == 11) checkOutput("wrap_zero", jobs_f, 0);
        end
        checkOutput("wrap_jobs", jobs_f, 1);
        jv_f   = 1'b0;
        idle_f = 4'b0000;
        applyStimulus;

        // Mid-operation reset clears the fresh grant asynchronously
        idle_f = 4'b1000;
        jv_f   = 1'b1;
        applyStimulus;
        checkOutput("mid_gv_before", gv_f, 1);
        checkOutput("mid_grant_before", grant_f, 4'b1000);
        reset = 1'b1;
        #1;
        checkOutput("mid_gv", gv_f, 0);
        checkOutput("mid_grant", grant_f, 4'b0000);
        checkOutput("mid_jobs", jobs_f, 0);
        checkOutput("mid_idx", idx_f, 0);
        applyStimulus;
        reset = 1'b0;
        jv_f  = 1'b0;

`ifdef DISPATCH_STATS_EN
        idle_f = 4'b0000;
        jv_f   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            applyStimulus;
        end
        checkOutput("stall_cycles", stall_f, 5);
        jv_f = 1'b0;
        applyStimulus;
        checkOutput("stall_hold", stall_f, 5);
`endif

        // Round-robin rotation, pend cleared by an idle-low gap each job
        for (int k = 0; k < 8; k++) begin
            idle_r = 4'b1111;
            jv_r   = 1'b1;
            applyStimulus;
            checkOutput("rr_grant", grant_r, rr_exp[k]);
            checkOutput("rr_idx", idx_r, rr_idx_exp[k]);
            idle_r = 4'b0000;
            jv_r   = 1'b0;
            applyStimulus;
            checkOutput("rr_gap", gv_r, 0);
        end
        checkOutput("rr_jobs", jobs_r, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
